// File: rtl/sr_ff_pkg.sv
// Shared definitions for the sr_ff SR flip-flop bank: S=R=1 resolution modes,
// counter width and the per-bit next-state helper.
package sr_ff_pkg;

    typedef logic [1:0] sr_mode_t;

    localparam sr_mode_t SR_INV_HOLD   = 2'd0;
    localparam sr_mode_t SR_INV_SET    = 2'd1;
    localparam sr_mode_t SR_INV_RST    = 2'd2;
    localparam sr_mode_t SR_INV_TOGGLE = 2'd3;

    localparam int SR_CNT_W = 16;

    // Next value of one SR bit given its current state, requests and S=R=1 policy.
    function automatic logic sr_resolve(input logic q, input logic s, input logic r,
                                        input sr_mode_t mode);
        logic both_v;
        logic res_v;
        case (mode)
            SR_INV_SET:    both_v = 1'b1;
            SR_INV_RST:    both_v = 1'b0;
            SR_INV_TOGGLE: both_v = ~q;
            default:       both_v = q;
        endcase
        case ({s, r})
            2'b10:   res_v = 1'b1;
            2'b01:   res_v = 1'b0;
            2'b11:   res_v = both_v;
            default: res_v = q;
        endcase
        return res_v;
    endfunction

endpackage

// File: rtl/sr_ff_bit.sv
// One SR storage bit with its registered single-cycle invalid (S=R=1) pulse.
module sr_ff_bit
    import sr_ff_pkg::*;
#(
    parameter sr_mode_t MODE      = SR_INV_HOLD,
    parameter logic     RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    output logic q,
    output logic invalid
);

    logic q_next_s;
    logic inv_next_s;
    logic q_r;
    logic inv_r;

    // Next-state and invalid-pulse decode from the sampled requests.
    always_comb begin
        q_next_s   = sr_resolve(q_r, s, r, MODE);
        inv_next_s = s & r;
    end

    // State and invalid pulse registers; invalid reflects only the latest edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= RESET_VAL;
            inv_r <= 1'b0;
        end else begin
            q_r   <= q_next_s;
            inv_r <= inv_next_s;
        end
    end

    assign q       = q_r;
    assign invalid = inv_r;

endmodule

// File: rtl/sr_ff.sv
// Vectorised SR flip-flop bank with illegal-input detection and sticky error flag.
// Optional feature macro: SR_FF_INVALID_CNT_EN adds a saturating 16-bit count of
// edges that sampled any S=R=1 bit (output invalid_cnt).
module sr_ff
    import sr_ff_pkg::*;
#(
    parameter int   WIDTH        = 1,
    parameter int   INVALID_MODE = 0,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] invalid,
    output logic             err_sticky
`ifdef SR_FF_INVALID_CNT_EN
    ,
    output logic [SR_CNT_W-1:0] invalid_cnt
`endif
);

    // Out-of-range modes fall back to hold so q can never go unknown.
    localparam sr_mode_t MODE = ((INVALID_MODE < 32'sd0) || (INVALID_MODE > 32'sd3))
                                ? SR_INV_HOLD : sr_mode_t'(INVALID_MODE);

    logic any_invalid_s;
    logic err_r;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        sr_ff_bit #(
            .MODE      (MODE),
            .RESET_VAL (RESET_VAL)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .s       (s[g]),
            .r       (r[g]),
            .q       (q[g]),
            .invalid (invalid[g])
        );
    end

    assign qn = ~q;

    // Any bit of the bank sampling S=R=1 on this edge.
    always_comb begin
        any_invalid_s = |(s & r);
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | any_invalid_s;
        end
    end

    assign err_sticky = err_r;

`ifdef SR_FF_INVALID_CNT_EN
    localparam logic [SR_CNT_W-1:0] CNT_MAX = {SR_CNT_W{1'b1}};
    localparam logic [SR_CNT_W-1:0] CNT_ONE = {{(SR_CNT_W-1){1'b0}}, 1'b1};

    logic [SR_CNT_W-1:0] cnt_r;

    // Saturating count of invalid edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {SR_CNT_W{1'b0}};
        end else if (any_invalid_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign invalid_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_sr_ff.sv
// Self-checking bench for sr_ff: six configurations run side by side against a
// rule-level model, plus hand-computed expectations for the key scenarios.
module tb_sr_ff;

    localparam int NDUT = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] s;
    logic [3:0] r;

    logic [3:0]  q_a   [NDUT];
    logic [3:0]  qn_a  [NDUT];
    logic [3:0]  inv_a [NDUT];
    logic        err_a [NDUT];
    logic [15:0] cnt_a [NDUT];

    logic [3:0]  mq    [NDUT];
    logic [3:0]  minv  [NDUT];
    logic        merr  [NDUT];
    logic [15:0] mcnt  [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // dut0..3: WIDTH=1 modes 0..3; dut4: WIDTH=4 mode 0; dut5: WIDTH=4 toggle, reset value 1
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WW = (g >= 4) ? 4 : 1;
        logic [WW-1:0] q_w, qn_w, inv_w;
        logic          err_w;
`ifdef SR_FF_INVALID_CNT_EN
        logic [15:0]   cnt_w;
`endif
        sr_ff #(
            .WIDTH        (WW),
            .INVALID_MODE ((g < 4) ? g : ((g == 4) ? 0 : 3)),
            .RESET_VAL    ((g == 5) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .s          (s[WW-1:0]),
            .r          (r[WW-1:0]),
            .q          (q_w),
            .qn         (qn_w),
            .invalid    (inv_w),
            .err_sticky (err_w)
`ifdef SR_FF_INVALID_CNT_EN
            ,
            .invalid_cnt(cnt_w)
`endif
        );
        assign q_a[g]   = 4'(q_w);
        assign qn_a[g]  = 4'(qn_w);
        assign inv_a[g] = 4'(inv_w);
        assign err_a[g] = err_w;
`ifdef SR_FF_INVALID_CNT_EN
        assign cnt_a[g] = cnt_w;
`else
        assign cnt_a[g] = 16'd0;
`endif
    end

    function automatic logic [3:0] mask_of(input int i);
        return (i >= 4) ? 4'hF : 4'h1;
    endfunction

    function automatic int mode_of(input int i);
        return (i < 4) ? i : ((i == 4) ? 0 : 3);
    endfunction

    // Rule table: set wins alone, reset wins alone, idle holds, both -> mode policy.
    function automatic logic [3:0] model_next(input logic [3:0] cur, input logic [3:0] sv,
                                              input logic [3:0] rv, input int mode,
                                              input logic [3:0] m);
        logic [3:0] n;
        n = cur;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) begin
                if (sv[b] && !rv[b])      n[b] = 1'b1;
                else if (rv[b] && !sv[b]) n[b] = 1'b0;
                else if (sv[b] && rv[b]) begin
                    if (mode == 1)      n[b] = 1'b1;
                    else if (mode == 2) n[b] = 1'b0;
                    else if (mode == 3) n[b] = ~cur[b];
                    else                n[b] = cur[b];
                end
            end
        end
        return n;
    endfunction

    // Reference model updated on the same edges the design sees.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                mq[i]   <= (i == 5) ? 4'hF : 4'h0;
                minv[i] <= 4'h0;
                merr[i] <= 1'b0;
                mcnt[i] <= 16'd0;
            end else begin
                mq[i]   <= model_next(mq[i], s, r, mode_of(i), mask_of(i));
                minv[i] <= s & r & mask_of(i);
                merr[i] <= merr[i] | (|(s & r & mask_of(i)));
                if ((|(s & r & mask_of(i))) && (mcnt[i] != 16'hFFFF))
                    mcnt[i] <= mcnt[i] + 16'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("model q dut%0d", i), 32'(q_a[i]), 32'(mq[i]));
            chk($sformatf("model qn dut%0d", i), 32'(qn_a[i]), 32'(~mq[i] & mask_of(i)));
            chk($sformatf("model invalid dut%0d", i), 32'(inv_a[i]), 32'(minv[i]));
            chk($sformatf("model err dut%0d", i), 32'(err_a[i]), 32'(merr[i]));
`ifdef SR_FF_INVALID_CNT_EN
            chk($sformatf("model cnt dut%0d", i), 32'(cnt_a[i]), 32'(mcnt[i]));
`endif
        end
    end

    task automatic apply(input logic [3:0] sv, input logic [3:0] rv);
        s = sv;
        r = rv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        s     = 4'h0;
        r     = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset q", 32'(q_a[0]), 32'h0);
        chk("reset qn", 32'(qn_a[0]), 32'h1);
        chk("reset value dut5", 32'(q_a[5]), 32'hF);
        rst_n = 1'b1;

        // s/r = 00,10,01,11,00 on the hold-mode bit
        apply(4'h0, 4'h0); chk("seq00 q", 32'(q_a[0]), 32'h0);
        apply(4'h1, 4'h0); chk("seq10 q", 32'(q_a[0]), 32'h1);
                           chk("seq10 inv", 32'(inv_a[0]), 32'h0);
        apply(4'h0, 4'h1); chk("seq01 q", 32'(q_a[0]), 32'h0);
        apply(4'h1, 4'h1); chk("seq11 q", 32'(q_a[0]), 32'h0);
                           chk("seq11 inv", 32'(inv_a[0]), 32'h1);
                           chk("seq11 err", 32'(err_a[0]), 32'h1);
        apply(4'h0, 4'h0); chk("seq00b inv", 32'(inv_a[0]), 32'h0);
                           chk("seq00b err", 32'(err_a[0]), 32'h1);

        // Clear everything, then two S=R=1 edges per mode
        apply(4'h0, 4'hF);
        apply(4'h1, 4'h1);
        chk("set-dom 1", 32'(q_a[1]), 32'h1);
        chk("rst-dom 1", 32'(q_a[2]), 32'h0);
        chk("toggle 1", 32'(q_a[3]), 32'h1);
        apply(4'h1, 4'h1);
        chk("set-dom 2", 32'(q_a[1]), 32'h1);
        chk("rst-dom 2", 32'(q_a[2]), 32'h0);
        chk("toggle 2", 32'(q_a[3]), 32'h0);
        chk("inv back-to-back", 32'(inv_a[0]), 32'h1);
`ifdef SR_FF_INVALID_CNT_EN
        chk("cnt after 3", 32'(cnt_a[0]), 32'h3);
`endif

        // WIDTH=4 independence
        apply(4'b0101, 4'b0011);
        chk("w4 q", 32'(q_a[4]), 32'h4);
        chk("w4 inv", 32'(inv_a[4]), 32'h1);

        // Async reset mid-cycle with q=1, invalid=1 and err_sticky=1
        apply(4'h1, 4'h0);
        apply(4'h1, 4'h1);
        chk("pre-reset q", 32'(q_a[0]), 32'h1);
        chk("pre-reset err", 32'(err_a[0]), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async q", 32'(q_a[0]), 32'h0);
        chk("async qn", 32'(qn_a[0]), 32'h1);
        chk("async inv", 32'(inv_a[0]), 32'h0);
        chk("async err", 32'(err_a[0]), 32'h0);
        chk("async dut5 q", 32'(q_a[5]), 32'hF);
`ifdef SR_FF_INVALID_CNT_EN
        chk("async cnt", 32'(cnt_a[0]), 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Set pulse that ends before the edge must leave q untouched
        s = 4'h1;
        r = 4'h0;
        #3;
        s = 4'h0;
        @(posedge clk);
        #1;
        chk("no transparency", 32'(q_a[0]), 32'h0);

        // Mixed vectors checked by the model
        for (int k = 0; k < 40; k++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        apply(4'h0, 4'h0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
